// File: rtl/kgp_mon_pkg.sv
// Shared types for the KGPRISC run monitor: FSM state encoding and write-counter width.
package kgp_mon_pkg;

    typedef enum logic [1:0] {
        MON_IDLE,
        MON_RUN,
        MON_DONE
    } mon_state_t;

    localparam int WRCNT_W = 16;

endpackage

// File: rtl/kgp_mon_if.sv
// Register-file write port as seen by the run monitor; the datapath drives it, the monitor snoops.
interface kgp_mon_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]     wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/kgp_mon_channel.sv
// One watched register: shadow copy, address decode and compare against the expected value.
// Latency: shadow updates on the edge that samples the write; match is combinational from the shadow.
// Backpressure: none, the register-file write port cannot be stalled.
module kgp_mon_channel #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_acc,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [REG_ADDR_W-1:0] watch_addr,
    input  logic [DATA_W-1:0]     expect_data,
    output logic [DATA_W-1:0]     shadow,
    output logic                  match,
    output logic                  match_nxt
);

    logic hit;

    assign hit = wr_acc && (wr_addr == watch_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
        end else if (clear) begin
            shadow <= '0;
        end else if (hit) begin
            shadow <= wr_data;
        end
    end

    assign match = (shadow == expect_data);
    // Value the compare will take after this edge, so a halt write that also lands here counts.
    assign match_nxt = hit ? (wr_data == expect_data) : match;

endmodule

// File: rtl/kgp_run_monitor.sv
// End-of-program monitor: shadows watched registers, detects the halt write, enforces a cycle timeout.
// Latency: halt write sampled at edge N gives done after that edge; timeout fires TIMEOUT_CYC cycles after RUN entry.
// Backpressure: none; pure snooper. Optional KGP_MON_WRCNT_EN adds a saturating wr_count output.
module kgp_run_monitor
    import kgp_mon_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int NUM_WATCH   = 2,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 1250
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    kgp_mon_if.slave                        wr,
    input  logic [NUM_WATCH*REG_ADDR_W-1:0] watch_addr,
    input  logic [NUM_WATCH*DATA_W-1:0]     expect_data,
    input  logic [REG_ADDR_W-1:0]           halt_addr,
    input  logic [DATA_W-1:0]               halt_value,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic                            timed_out,
    output logic [NUM_WATCH-1:0]            match_mask,
    output logic [NUM_WATCH*DATA_W-1:0]     shadow_data
`ifdef KGP_MON_WRCNT_EN
    ,
    output logic [WRCNT_W-1:0]              wr_count
`endif
);

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    mon_state_t            state;
    logic [TIMEOUT_W-1:0]  cnt;
    logic                  in_run;
    logic                  enter_run;
    logic                  wr_acc;
    logic                  halt_hit;
    logic                  cnt_last;
    logic [NUM_WATCH-1:0]  match_nxt;

    assign in_run    = (state == MON_RUN);
    assign enter_run = start && !in_run;
    // R0 is hardwired zero in the register file, so writes to it never reach a shadow.
    assign wr_acc    = in_run && wr.wr_en && (wr.wr_addr != '0);
    assign halt_hit  = in_run && wr.wr_en && (wr.wr_addr == halt_addr) && (wr.wr_data == halt_value);
    assign cnt_last  = (cnt == CNT_LAST);

    for (genvar i = 0; i < NUM_WATCH; i++) begin : g_ch
        kgp_mon_channel #(
            .DATA_W     (DATA_W),
            .REG_ADDR_W (REG_ADDR_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .clear       (enter_run),
            .wr_acc      (wr_acc),
            .wr_addr     (wr.wr_addr),
            .wr_data     (wr.wr_data),
            .watch_addr  (watch_addr[i*REG_ADDR_W +: REG_ADDR_W]),
            .expect_data (expect_data[i*DATA_W +: DATA_W]),
            .shadow      (shadow_data[i*DATA_W +: DATA_W]),
            .match       (match_mask[i]),
            .match_nxt   (match_nxt[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= MON_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                MON_IDLE, MON_DONE: begin
                    if (start) begin
                        state     <= MON_RUN;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        timed_out <= 1'b0;
                    end
                end
                MON_RUN: begin
                    cnt <= cnt + TIMEOUT_W'(1);
                    // Halt takes priority over a timeout landing on the same cycle.
                    if (halt_hit) begin
                        state     <= MON_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= &match_nxt;
                        timed_out <= 1'b0;
                    end else if (cnt_last) begin
                        state     <= MON_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        timed_out <= 1'b1;
                    end
                end
                default: begin
                    state <= MON_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef KGP_MON_WRCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count <= '0;
        end else if (enter_run) begin
            wr_count <= '0;
        end else if (wr_acc && (wr_count != '1)) begin
            wr_count <= wr_count + WRCNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_kgp_run_monitor.sv
// Scoreboard bench for kgp_run_monitor: expected end-of-run results queued at stimulus, checked on done.
module tb_kgp_run_monitor;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NW = 2;
    localparam int TW = 16;
    localparam int TC = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                start;
    logic [NW*AW-1:0]    watch_addr;
    logic [NW*DW-1:0]    expect_data;
    logic [AW-1:0]       halt_addr;
    logic [DW-1:0]       halt_value;
    logic                busy, done, pass, timed_out;
    logic [NW-1:0]       match_mask;
    logic [NW*DW-1:0]    shadow_data;
`ifdef KGP_MON_WRCNT_EN
    logic [15:0]         wr_count;
`endif

    kgp_mon_if #(.DATA_W(DW), .REG_ADDR_W(AW)) wif ();

    kgp_run_monitor #(
        .DATA_W      (DW),
        .REG_ADDR_W  (AW),
        .NUM_WATCH   (NW),
        .TIMEOUT_W   (TW),
        .TIMEOUT_CYC (TC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .wr          (wif),
        .watch_addr  (watch_addr),
        .expect_data (expect_data),
        .halt_addr   (halt_addr),
        .halt_value  (halt_value),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timed_out   (timed_out),
        .match_mask  (match_mask),
        .shadow_data (shadow_data)
`ifdef KGP_MON_WRCNT_EN
        ,
        .wr_count    (wr_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic          pass;
        logic          to;
        logic [DW-1:0] s0;
        logic [DW-1:0] s1;
        logic [NW-1:0] mask;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic done_q = 1'b0;

    // Score every rising edge of done against the oldest queued expectation.
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                cur = sb.pop_front();
                check("sb_pass",      64'(pass),                 64'(cur.pass));
                check("sb_timed_out", 64'(timed_out),            64'(cur.to));
                check("sb_shadow0",   64'(shadow_data[DW-1:0]),  64'(cur.s0));
                check("sb_shadow1",   64'(shadow_data[2*DW-1:DW]), 64'(cur.s1));
                check("sb_mask",      64'(match_mask),           64'(cur.mask));
            end
        end
        done_q = done;
    end

    function automatic exp_t mk(input logic p, input logic t, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, input logic [NW-1:0] m);
        exp_t e;
        e.pass = p; e.to = t; e.s0 = a; e.s1 = b; e.mask = m;
        return e;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wr_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wif.wr_en   = 1'b1;
        wif.wr_addr = a;
        wif.wr_data = d;
        @(negedge clk);
        wif.wr_en   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) check("done_wait_expired", 64'd0, 64'd1);
    endtask

    int cyc;

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        wif.wr_en   = 1'b0;
        wif.wr_addr = '0;
        wif.wr_data = '0;
        watch_addr  = {5'd20, 5'd19};
        expect_data = {32'd0, 32'd5};
        halt_addr   = 5'd16;
        halt_value  = 32'd1;
        #12;
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_done",   64'(done), 64'd0);
        check("rst_pass",   64'(pass), 64'd0);
        check("rst_to",     64'(timed_out), 64'd0);
        check("rst_shadow", 64'(shadow_data == '0), 64'd1);
        check("rst_mask",   64'(match_mask), 64'b10);
`ifdef KGP_MON_WRCNT_EN
        check("rst_wrcnt",  64'(wr_count), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Found: R19=5 then halt.
        pulse_start();
        check("run_busy", 64'(busy), 64'd1);
        wr_reg(5'd19, 32'd5);
        sb.push_back(mk(1'b1, 1'b0, 32'd5, 32'd0, 2'b11));
        check("pre_halt_done", 64'(done), 64'd0);
        wr_reg(5'd16, 32'd1);
        wait_done(20, cyc);
        check("halt_latency", 64'(cyc), 64'd0);
        check("done_busy", 64'(busy), 64'd0);

        // Restart from DONE; second channel spoils the pass.
        pulse_start();
        check("restart_busy",   64'(busy), 64'd1);
        check("restart_done",   64'(done), 64'd0);
        check("restart_shadow", 64'(shadow_data == '0), 64'd1);
        wr_reg(5'd20, 32'd9);
        wr_reg(5'd19, 32'd5);
        sb.push_back(mk(1'b0, 1'b0, 32'd5, 32'd9, 2'b01));
        wr_reg(5'd16, 32'd1);
        wait_done(20, cyc);
        check("halt_latency2", 64'(cyc), 64'd0);

        // Not found: all-ones written where 5 is expected.
        pulse_start();
        wr_reg(5'd19, 32'hFFFF_FFFF);
        sb.push_back(mk(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0, 2'b10));
        wr_reg(5'd16, 32'd1);
        wait_done(20, cyc);

        // Writes in DONE must not disturb the frozen shadows.
        wr_reg(5'd19, 32'd5);
        check("done_frozen", 64'(shadow_data[DW-1:0]), 64'hFFFF_FFFF);
        check("done_held",   64'(done), 64'd1);

        // Timeout with no halt.
        pulse_start();
        sb.push_back(mk(1'b0, 1'b1, 32'd0, 32'd0, 2'b10));
        wait_done(40, cyc);
        check("timeout_cycles", 64'(cyc), 64'(TC));

        // Halt collides with the last timeout cycle on a watched register.
        halt_addr  = 5'd19;
        halt_value = 32'd5;
        pulse_start();
        sb.push_back(mk(1'b1, 1'b0, 32'd5, 32'd0, 2'b11));
        repeat (TC - 1) @(negedge clk);
        wr_reg(5'd19, 32'd5);
        wait_done(20, cyc);
        check("collision_latency", 64'(cyc), 64'd0);

        // R0 writes are dropped even when R0 is watched.
        halt_addr   = 5'd16;
        halt_value  = 32'd1;
        watch_addr  = {5'd20, 5'd0};
        pulse_start();
        wr_reg(5'd0, 32'd5);
        check("r0_shadow", 64'(shadow_data[DW-1:0]), 64'd0);
        sb.push_back(mk(1'b0, 1'b0, 32'd0, 32'd0, 2'b10));
        wr_reg(5'd16, 32'd1);
        wait_done(20, cyc);

        // Asynchronous reset in the middle of a run.
        watch_addr = {5'd20, 5'd19};
        pulse_start();
        wr_reg(5'd19, 32'd5);
        check("midrun_shadow", 64'(shadow_data[DW-1:0]), 64'd5);
        #2 rst = 1'b0;
        #1;
        check("arst_busy",   64'(busy), 64'd0);
        check("arst_done",   64'(done), 64'd0);
        check("arst_shadow", 64'(shadow_data == '0), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (TC + 4) @(negedge clk);
        check("post_arst_done", 64'(done), 64'd0);
        check("post_arst_busy", 64'(busy), 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
